inst_fetch_loader: RTL and testbench
====================================

# inst_fetch_loader

Parametrised instruction-fetch stage with integrated program loader. Holds an inferred instruction memory of 2^INST_MEM_WIDTH words. During load mode it writes words from the serial loader sequentially from address 0, using a toggle handshake. During run mode it returns the registered instruction at `pc`, along with PC values delayed to match. It sits between the program-loader front end and decode, and adds over-length detection, a fetch stall and load status over the previous fetch stage.

## Interface
- `INST_MEM_WIDTH`, default 14: instruction address width; memory depth is 2^INST_MEM_WIDTH words of 32 bits.
- `IDLE_INST`, default 32'hffffffff: value driven on `inst` while not in RUN and after reset.
- `CLK`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `pc`  in  INST_MEM_WIDTH  fetch address.
- `pc1`  in  INST_MEM_WIDTH  companion PC (pc+1 from the PC unit); pipelined alongside `pc`.
- `fetch_stall`  in  1  hold all fetch outputs.
- `input_data`  in  32  loader word.
- `input_start`  in  1  begin load (single-cycle pulse).
- `input_end`  in  1  end load (single-cycle pulse).
- `input_valid`  in  1  toggle strobe; every change of level marks one new word.
- `inst`  out  32  fetched instruction.
- `inst_enable`  out  1  high only in RUN.
- `pc_next`  out  INST_MEM_WIDTH  `pc` aligned to `inst`.
- `pc1_next`  out  INST_MEM_WIDTH  `pc1` aligned to `inst`.
- `load_busy`  out  1  high in LOAD or DRAIN.
- `load_count`  out  INST_MEM_WIDTH+1  words written since the last `input_start`.
- `load_overflow`  out  1  sticky; a word arrived when the memory was full.
- `load_checksum`  out  32  see Configuration.

## Operation
- Reset values: state RUN, `inst`=IDLE_INST, `inst_enable`=1, `pc_next`=0, `pc1_next`=0, `load_busy`=0, `load_count`=0, `load_overflow`=0, `load_checksum`=0, `valid_buf`=0, `wr_pend`=0, write address 0. Memory contents are not cleared.
- FSM states: RUN, LOAD, DRAIN.
  - `input_start` in any state moves to LOAD and clears write address, `load_count`, `load_overflow` and `load_checksum`. `input_start` takes priority over `input_end` when both are high.
  - `input_end` in LOAD moves to DRAIN. DRAIN always moves to RUN after exactly one cycle.
  - `input_end` in RUN or DRAIN is ignored.
- Toggle tracking runs in every state. `valid_buf` follows `input_valid` whenever they differ. A word is captured (`data_buf`<=`input_data`, `wr_pend`<=1) only when the toggle is detected in LOAD. Toggles seen in RUN or DRAIN are absorbed without a write.
- Write: when `wr_pend`=1, `mem[wr_addr]`<=`data_buf`, `wr_addr`++ and `load_count`++; `wr_pend` clears unless a new word is captured in the same cycle.
- Full: when `load_count`=2^INST_MEM_WIDTH, a pending word is dropped and `load_overflow` is set. The write address never wraps onto earlier words.
- A toggle arriving in the same cycle as `input_end` is captured and written during DRAIN.
- Fetch, in RUN and with `fetch_stall`=0: `inst`<=`mem[pc]`, `pc_next`<=`pc`, `pc1_next`<=`pc1`.
- Fetch with `fetch_stall`=1: all three outputs hold.
- In LOAD and DRAIN: `inst`=IDLE_INST and `inst_enable`=0; `pc_next`/`pc1_next` still track when not stalled.
- Reset during a load returns to RUN. Partially loaded words stay in memory; counters clear.

## Timing
- Fetch latency is 1 cycle: `pc` presented at edge t gives `inst`, `pc_next` and `pc1_next` valid after edge t+1.
- Loader path: toggle sampled at edge t → captured at t → written at t+1 → `load_count` updates after t+1. The loader may toggle at most once per cycle.
- Mode change on `input_end` at edge t:
  - DRAIN after t.
  - RUN and `inst_enable`=1 after t+1.
  - First valid fetch data after t+2.
- `input_start` at edge t: `inst_enable`=0 and `inst`=IDLE_INST after t.

## Configuration
- `LOADER_CHECKSUM_EN` defined: `load_checksum` is the 32-bit wrapping sum of every written word, cleared on `input_start`. Dropped overflow words are excluded.
- `LOADER_CHECKSUM_EN` undefined: `load_checksum` is tied to 0 and no adder is built. The port is always present.

## Test plan
- Reset, then hold `pc`=5 → `inst`=32'hffffffff, `inst_enable`=1, `pc_next`=0 for the reset cycle; no X on any output.
- Load 4 words (0x11,0x22,0x33,0x44) with 4 toggles, then `input_end`; read pc=0..3 → `inst`=0x11..0x44 one cycle after each pc; `load_count`=4; `load_checksum`=0xAA with macro, 0 without.
- INST_MEM_WIDTH=2: toggle 5 words → `load_count`=4, `load_overflow`=1, mem[0] still holds word 1.
- `input_start` and `input_end` asserted together in LOAD → stays in LOAD and counters clear. Toggle in the same cycle as `input_end` → word written and `load_count` increments during DRAIN.
- `fetch_stall`=1 for 3 cycles while `pc` changes 0→1→2 → `inst`/`pc_next` hold their pc=0 values, then resume.
- Reset mid-load after 2 words → RUN, `load_count`=0, mem[0..1] retain the loaded words.

Source files
------------

// File: rtl/inst_fetch_loader_if.sv
// inst_fetch_loader_if: fetch and serial-loader signal bundle.
// slave is the fetch stage view, master is the driver view.
interface inst_fetch_loader_if #(
  parameter int W = 14
);
  logic [W-1:0] pc;
  logic [W-1:0] pc1;
  logic         fetch_stall;
  logic [31:0]  input_data;
  logic         input_start;
  logic         input_end;
  logic         input_valid;
  logic [31:0]  inst;
  logic         inst_enable;
  logic [W-1:0] pc_next;
  logic [W-1:0] pc1_next;
  logic         load_busy;
  logic [W:0]   load_count;
  logic         load_overflow;
  logic [31:0]  load_checksum;

  modport slave (
    input  pc, pc1, fetch_stall,
    input  input_data, input_start,
    input  input_end, input_valid,
    output inst, inst_enable,
    output pc_next, pc1_next,
    output load_busy, load_count,
    output load_overflow, load_checksum
  );

  modport master (
    output pc, pc1, fetch_stall,
    output input_data, input_start,
    output input_end, input_valid,
    input  inst, inst_enable,
    input  pc_next, pc1_next,
    input  load_busy, load_count,
    input  load_overflow, load_checksum
  );
endinterface

// File: rtl/inst_fetch_loader.sv
// inst_fetch_loader: fetch stage with toggle-handshake program loader.
// Define LOADER_CHECKSUM_EN to build the load_checksum accumulator.
module inst_fetch_loader #(
  parameter int          INST_MEM_WIDTH = 14,
  parameter logic [31:0] IDLE_INST      = 32'hffffffff
) (
  input logic CLK,
  input logic reset,
  inst_fetch_loader_if.slave bus
);
  localparam int AW    = INST_MEM_WIDTH;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] ONE_A = 1;
  localparam logic [AW:0]   ONE_C = 1;
  localparam logic [AW:0]   FULL_CNT =
    {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {
    RUN, LOAD, DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [31:0]   mem [DEPTH];
  logic [31:0]   inst_q, inst_d;
  logic [AW-1:0] pc_next_q, pc_next_d;
  logic [AW-1:0] pc1_next_q, pc1_next_d;
  logic          valid_buf_q;
  logic          wr_pend_q, wr_pend_d;
  logic [31:0]   data_buf_q, data_buf_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  logic toggle, capture, full, do_wr, drop;

  assign toggle  = bus.input_valid ^ valid_buf_q;
  assign capture = toggle && (state_q == LOAD);
  assign full    = (cnt_q == FULL_CNT);
  // A start cancels a word still pending from the previous load.
  assign do_wr   = wr_pend_q && !full && !bus.input_start;
  assign drop    = wr_pend_q && full && !bus.input_start;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     state_d = RUN;
      LOAD:    if (bus.input_end) state_d = DRAIN;
      DRAIN:   state_d = RUN;
      default: state_d = RUN;
    endcase
    if (bus.input_start) state_d = LOAD;
  end

  always_comb begin
    wr_addr_d  = wr_addr_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    wr_pend_d  = capture;
    data_buf_d = capture ? bus.input_data : data_buf_q;
    if (bus.input_start) begin
      wr_addr_d = '0;
      cnt_d     = '0;
      ovf_d     = 1'b0;
    end else if (do_wr) begin
      wr_addr_d = wr_addr_q + ONE_A;
      cnt_d     = cnt_q + ONE_C;
    end else if (drop) begin
      ovf_d = 1'b1;
    end
  end

  // Output stays idle through the DRAIN->RUN edge.
  always_comb begin
    inst_d     = inst_q;
    pc_next_d  = pc_next_q;
    pc1_next_d = pc1_next_q;
    if (!bus.fetch_stall) begin
      pc_next_d  = bus.pc;
      pc1_next_d = bus.pc1;
    end
    if (state_d != RUN || state_q != RUN)
      inst_d = IDLE_INST;
    else if (!bus.fetch_stall)
      inst_d = mem[bus.pc];
  end

  always_ff @(posedge CLK) begin
    if (do_wr) mem[wr_addr_q] <= data_buf_q;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= RUN;
      inst_q      <= IDLE_INST;
      pc_next_q   <= '0;
      pc1_next_q  <= '0;
      valid_buf_q <= 1'b0;
      wr_pend_q   <= 1'b0;
      data_buf_q  <= '0;
      wr_addr_q   <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      inst_q      <= inst_d;
      pc_next_q   <= pc_next_d;
      pc1_next_q  <= pc1_next_d;
      valid_buf_q <= bus.input_valid;
      wr_pend_q   <= wr_pend_d;
      data_buf_q  <= data_buf_d;
      wr_addr_q   <= wr_addr_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (bus.input_start) csum_d = '0;
    else if (do_wr)      csum_d = csum_q + data_buf_q;
  end

  always_ff @(posedge CLK) begin
    if (reset) csum_q <= '0;
    else       csum_q <= csum_d;
  end

  assign bus.load_checksum = csum_q;
`else
  assign bus.load_checksum = '0;
`endif

  assign bus.inst          = inst_q;
  assign bus.inst_enable   = (state_q == RUN);
  assign bus.pc_next       = pc_next_q;
  assign bus.pc1_next      = pc1_next_q;
  assign bus.load_busy     = (state_q != RUN);
  assign bus.load_count    = cnt_q;
  assign bus.load_overflow = ovf_q;
endmodule

// File: tb/tb_inst_fetch_loader.sv
// tb_inst_fetch_loader: directed tests for inst_fetch_loader.
// A second instance with INST_MEM_WIDTH=2 covers the full-memory case.
module tb_inst_fetch_loader;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  inst_fetch_loader_if #(.W(14)) bus ();
  inst_fetch_loader_if #(.W(2))  sbus ();

  inst_fetch_loader #(.INST_MEM_WIDTH(14)) u_dut (
    .CLK(clk), .reset(reset), .bus(bus)
  );

  inst_fetch_loader #(.INST_MEM_WIDTH(2)) u_small (
    .CLK(clk), .reset(reset), .bus(sbus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_word(input logic [31:0] d);
    bus.input_data  = d;
    bus.input_valid = ~bus.input_valid;
    tick();
  endtask

  task automatic pulse_start();
    bus.input_start = 1'b1;
    tick();
    bus.input_start = 1'b0;
  endtask

  task automatic read_pc(input int p, input logic [31:0] exp);
    bus.pc  = p[13:0];
    bus.pc1 = 14'(p + 1);
    tick();
    checks++;
    if (bus.inst !== exp) begin
      errors++;
      $display("FAIL read_inst pc=%0d: got %h expected %h", p, bus.inst, exp);
    end
    checks++;
    if (bus.pc_next !== p[13:0] || bus.pc1_next !== 14'(p + 1)) begin
      errors++;
      $display("FAIL read_pc pc=%0d: got %0d/%0d expected %0d/%0d",
               p, bus.pc_next, bus.pc1_next, p, p + 1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.pc = 14'd5; bus.pc1 = 14'd6; bus.fetch_stall = 1'b0;
    bus.input_data = '0; bus.input_start = 1'b0;
    bus.input_end = 1'b0; bus.input_valid = 1'b0;
    sbus.pc = '0; sbus.pc1 = '0; sbus.fetch_stall = 1'b0;
    sbus.input_data = '0; sbus.input_start = 1'b0;
    sbus.input_end = 1'b0; sbus.input_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.inst !== 32'hffffffff || bus.inst_enable !== 1'b1) begin
      errors++;
      $display("FAIL reset_inst: got %h/%b expected ffffffff/1", bus.inst, bus.inst_enable);
    end
    checks++;
    if (bus.pc_next !== 14'd0 || bus.pc1_next !== 14'd0) begin
      errors++;
      $display("FAIL reset_pc: got %0d/%0d expected 0/0", bus.pc_next, bus.pc1_next);
    end
    checks++;
    if (bus.load_busy !== 1'b0 || bus.load_count !== 15'd0 ||
        bus.load_overflow !== 1'b0 || bus.load_checksum !== 32'd0) begin
      errors++;
      $display("FAIL reset_load: got busy=%b cnt=%0d ovf=%b sum=%h expected 0/0/0/0",
               bus.load_busy, bus.load_count, bus.load_overflow, bus.load_checksum);
    end
    checks++;
    if ($isunknown({bus.inst, bus.inst_enable, bus.pc_next, bus.pc1_next,
                    bus.load_busy, bus.load_count, bus.load_overflow,
                    bus.load_checksum})) begin
      errors++;
      $display("FAIL reset_x: outputs contain X, expected none");
    end
    reset = 1'b0;
  endtask

  task automatic test_load();
    logic [31:0] exp_sum;
`ifdef LOADER_CHECKSUM_EN
    exp_sum = 32'hAA;
`else
    exp_sum = 32'h0;
`endif
    put_word(32'hDEAD);
    tick();
    pulse_start();
    checks++;
    if (bus.inst_enable !== 1'b0 || bus.inst !== 32'hffffffff ||
        bus.load_busy !== 1'b1) begin
      errors++;
      $display("FAIL load_enter: got en=%b inst=%h busy=%b expected 0/ffffffff/1",
               bus.inst_enable, bus.inst, bus.load_busy);
    end
    checks++;
    if (bus.load_count !== 15'd0) begin
      errors++;
      $display("FAIL run_toggle_absorbed: got %0d expected 0", bus.load_count);
    end
    put_word(32'h11);
    put_word(32'h22);
    put_word(32'h33);
    put_word(32'h44);
    bus.input_end = 1'b1;
    tick();
    bus.input_end = 1'b0;
    checks++;
    if (bus.load_count !== 15'd4 || bus.load_busy !== 1'b1 ||
        bus.inst_enable !== 1'b0) begin
      errors++;
      $display("FAIL load_drain: got cnt=%0d busy=%b en=%b expected 4/1/0",
               bus.load_count, bus.load_busy, bus.inst_enable);
    end
    tick();
    checks++;
    if (bus.load_busy !== 1'b0 || bus.inst_enable !== 1'b1) begin
      errors++;
      $display("FAIL load_run: got busy=%b en=%b expected 0/1",
               bus.load_busy, bus.inst_enable);
    end
    checks++;
    if (bus.load_checksum !== exp_sum) begin
      errors++;
      $display("FAIL load_checksum: got %h expected %h", bus.load_checksum, exp_sum);
    end
    read_pc(0, 32'h11);
    read_pc(1, 32'h22);
    read_pc(2, 32'h33);
    read_pc(3, 32'h44);
  endtask

  task automatic test_start_end();
    logic [31:0] exp_sum;
`ifdef LOADER_CHECKSUM_EN
    exp_sum = 32'h77;
`else
    exp_sum = 32'h0;
`endif
    pulse_start();
    put_word(32'h55);
    put_word(32'h66);
    tick();
    checks++;
    if (bus.load_count !== 15'd2) begin
      errors++;
      $display("FAIL se_pre: got %0d expected 2", bus.load_count);
    end
    bus.input_start = 1'b1;
    bus.input_end   = 1'b1;
    tick();
    bus.input_start = 1'b0;
    bus.input_end   = 1'b0;
    tick();
    checks++;
    if (bus.load_busy !== 1'b1 || bus.load_count !== 15'd0 ||
        bus.inst_enable !== 1'b0) begin
      errors++;
      $display("FAIL se_both: got busy=%b cnt=%0d en=%b expected 1/0/0",
               bus.load_busy, bus.load_count, bus.inst_enable);
    end
    bus.input_end = 1'b1;
    put_word(32'h77);
    bus.input_end = 1'b0;
    checks++;
    if (bus.load_count !== 15'd0 || bus.load_busy !== 1'b1) begin
      errors++;
      $display("FAIL se_end_tog: got cnt=%0d busy=%b expected 0/1",
               bus.load_count, bus.load_busy);
    end
    tick();
    checks++;
    if (bus.load_count !== 15'd1 || bus.load_checksum !== exp_sum) begin
      errors++;
      $display("FAIL se_drain_wr: got cnt=%0d sum=%h expected 1/%h",
               bus.load_count, bus.load_checksum, exp_sum);
    end
    read_pc(0, 32'h77);
    read_pc(1, 32'h66);
  endtask

  task automatic test_stall();
    read_pc(0, 32'h77);
    bus.fetch_stall = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bus.pc  = (i > 2) ? 14'd2 : 14'(i);
      bus.pc1 = bus.pc + 14'd1;
      tick();
      checks++;
      if (bus.inst !== 32'h77 || bus.pc_next !== 14'd0 ||
          bus.pc1_next !== 14'd1) begin
        errors++;
        $display("FAIL stall_hold c%0d: got %h/%0d/%0d expected 77/0/1",
                 i, bus.inst, bus.pc_next, bus.pc1_next);
      end
    end
    bus.fetch_stall = 1'b0;
    read_pc(2, 32'h33);
  endtask

  task automatic test_reset_midload();
    pulse_start();
    put_word(32'hA1);
    put_word(32'hA2);
    tick();
    checks++;
    if (bus.load_count !== 15'd2) begin
      errors++;
      $display("FAIL rm_pre: got %0d expected 2", bus.load_count);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (bus.load_count !== 15'd0 || bus.load_busy !== 1'b0 ||
        bus.inst_enable !== 1'b1) begin
      errors++;
      $display("FAIL rm_state: got cnt=%0d busy=%b en=%b expected 0/0/1",
               bus.load_count, bus.load_busy, bus.inst_enable);
    end
    read_pc(0, 32'hA1);
    read_pc(1, 32'hA2);
  endtask

  task automatic test_overflow();
    logic [31:0] exp_sum;
`ifdef LOADER_CHECKSUM_EN
    exp_sum = 32'd10;
`else
    exp_sum = 32'd0;
`endif
    sbus.input_start = 1'b1;
    tick();
    sbus.input_start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      sbus.input_data  = i;
      sbus.input_valid = ~sbus.input_valid;
      tick();
    end
    tick();
    tick();
    checks++;
    if (sbus.load_count !== 3'd4 || sbus.load_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flag: got cnt=%0d ovf=%b expected 4/1",
               sbus.load_count, sbus.load_overflow);
    end
    checks++;
    if (sbus.load_checksum !== exp_sum) begin
      errors++;
      $display("FAIL ovf_sum: got %h expected %h", sbus.load_checksum, exp_sum);
    end
    sbus.input_end = 1'b1;
    tick();
    sbus.input_end = 1'b0;
    tick();
    sbus.pc = 2'd0;
    tick();
    checks++;
    if (sbus.inst !== 32'd1) begin
      errors++;
      $display("FAIL ovf_mem0: got %h expected 00000001", sbus.inst);
    end
    sbus.pc = 2'd3;
    tick();
    checks++;
    if (sbus.inst !== 32'd4) begin
      errors++;
      $display("FAIL ovf_mem3: got %h expected 00000004", sbus.inst);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_start_end();
    test_stall();
    test_overflow();
    test_reset_midload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
